// File: rtl/ahbl_to_apb_bridge_pkg.sv
// Shared constants and state encoding for the AHB-Lite to APB3 bridge.
package ahbl_to_apb_bridge_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ  = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StWdata  = 3'd1,
      StSetup  = 3'd2,
      StAccess = 3'd3,
      StResp   = 3'd4,
      StErr0   = 3'd5,
      StErr1   = 3'd6
   } bridge_state_e;

endpackage

// File: rtl/ahbl_to_apb_bridge.sv
// AHB-Lite subordinate that turns single transfers into APB3 accesses, one at a time.
// All APB and AHB response outputs come straight from flops.
module ahbl_to_apb_bridge
   import ahbl_to_apb_bridge_pkg::*;
#(
   parameter int unsigned W_ADDR  = 32,
   parameter int unsigned W_DATA  = 32,
   parameter int unsigned W_PADDR = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ahbls_hready,
   output logic               ahbls_hready_resp,
   output logic               ahbls_hresp,
   input  logic               ahbls_hsel,
   input  logic [W_ADDR-1:0]  ahbls_haddr,
   input  logic               ahbls_hwrite,
   input  logic [1:0]         ahbls_htrans,
   input  logic [2:0]         ahbls_hsize,
   input  logic [W_DATA-1:0]  ahbls_hwdata,
   output logic [W_DATA-1:0]  ahbls_hrdata,
   output logic [W_PADDR-1:0] apbm_paddr,
   output logic               apbm_psel,
   output logic               apbm_penable,
   output logic               apbm_pwrite,
   output logic [W_DATA-1:0]  apbm_pwdata,
   input  logic [W_DATA-1:0]  apbm_prdata,
   input  logic               apbm_pready,
   input  logic               apbm_pslverr
);

   bridge_state_e state_q, state_d;
   logic          capture;
   logic          can_capture;

   logic unused_inputs;
   assign unused_inputs = ^{ahbls_haddr[W_ADDR-1:W_PADDR], ahbls_htrans[0]};

   assign can_capture = (state_q == StIdle) || (state_q == StResp) || (state_q == StErr1);
   assign capture     = can_capture && ahbls_hready && ahbls_hsel && ahbls_htrans[1];

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StResp, StErr1: begin
            if (!capture) begin
               state_d = StIdle;
            end else if (!ahbls_hwrite) begin
               state_d = StSetup;
            end else if (ahbls_hsize == HSIZE_WORD) begin
               state_d = StWdata;
            end else begin
               // Sub-word writes cannot be expressed on APB3: error without an APB access.
               state_d = StErr0;
            end
         end
         StWdata:  state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: begin
            if (apbm_pready) begin
               state_d = apbm_pslverr ? StErr0 : StResp;
            end
         end
         StErr0:   state_d = StErr1;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= StIdle;
         ahbls_hready_resp <= 1'b1;
         ahbls_hresp       <= 1'b0;
         ahbls_hrdata      <= '0;
         apbm_psel         <= 1'b0;
         apbm_penable      <= 1'b0;
         apbm_pwrite       <= 1'b0;
         apbm_paddr        <= '0;
         apbm_pwdata       <= '0;
      end else begin
         state_q           <= state_d;
         ahbls_hready_resp <= (state_d == StIdle) || (state_d == StResp) || (state_d == StErr1);
         ahbls_hresp       <= (state_d == StErr0) || (state_d == StErr1);
         apbm_psel         <= (state_d == StSetup) || (state_d == StAccess);
         apbm_penable      <= (state_d == StAccess);
         if (capture) begin
            apbm_paddr  <= ahbls_haddr[W_PADDR-1:0];
            apbm_pwrite <= ahbls_hwrite;
         end
         if (state_q == StWdata) begin
            apbm_pwdata <= ahbls_hwdata;
         end
         if ((state_q == StAccess) && apbm_pready && !apbm_pslverr && !apbm_pwrite) begin
            ahbls_hrdata <= apbm_prdata;
         end
      end
   end

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// Scoreboard bench for ahbl_to_apb_bridge: random AHB-Lite traffic against a behavioural APB model.
module tb_ahbl_to_apb_bridge;
   import ahbl_to_apb_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ahbls_hready_resp, ahbls_hresp, ahbls_hsel, ahbls_hwrite;
   logic [31:0] ahbls_haddr, ahbls_hwdata, ahbls_hrdata;
   logic [1:0]  ahbls_htrans;
   logic [2:0]  ahbls_hsize;
   logic [15:0] apbm_paddr;
   logic        apbm_psel, apbm_penable, apbm_pwrite, apbm_pready, apbm_pslverr;
   logic [31:0] apbm_pwdata, apbm_prdata;

   always #5 clk = ~clk;

   ahbl_to_apb_bridge #(.W_ADDR(32), .W_DATA(32), .W_PADDR(16)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ahbls_hready      (ahbls_hready_resp),
      .ahbls_hready_resp (ahbls_hready_resp),
      .ahbls_hresp       (ahbls_hresp),
      .ahbls_hsel        (ahbls_hsel),
      .ahbls_haddr       (ahbls_haddr),
      .ahbls_hwrite      (ahbls_hwrite),
      .ahbls_htrans      (ahbls_htrans),
      .ahbls_hsize       (ahbls_hsize),
      .ahbls_hwdata      (ahbls_hwdata),
      .ahbls_hrdata      (ahbls_hrdata),
      .apbm_paddr        (apbm_paddr),
      .apbm_psel         (apbm_psel),
      .apbm_penable      (apbm_penable),
      .apbm_pwrite       (apbm_pwrite),
      .apbm_pwdata       (apbm_pwdata),
      .apbm_prdata       (apbm_prdata),
      .apbm_pready       (apbm_pready),
      .apbm_pslverr      (apbm_pslverr)
   );

   typedef struct { logic write; logic [15:0] addr; logic [31:0] wdata; } apb_exp_t;
   typedef struct { int waits; logic err; logic [31:0] rdata; } apb_rsp_t;
   typedef struct { logic err; logic [31:0] hrdata; int lat; } ahb_exp_t;

   apb_exp_t apb_exp_q[$];
   apb_rsp_t apb_rsp_q[$];
   ahb_exp_t ahb_exp_q[$];

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mdl_hrdata = '0;
   logic [31:0] pend_wdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   task automatic bail(input string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s at %0t", what, $time);
      finish_run();
   endtask

   initial begin
      #300000;
      bail("watchdog_timeout");
   end

   // One AHB address-phase cycle, held until the bus accepts it.
   task automatic drive(input logic sel, input logic [1:0] trans, input logic write,
                        input logic [31:0] addr, input logic [2:0] size);
      int cnt;
      cnt          = 0;
      ahbls_hsel   = sel;
      ahbls_htrans = trans;
      ahbls_hwrite = write;
      ahbls_haddr  = addr;
      ahbls_hsize  = size;
      ahbls_hwdata = pend_wdata;
      @(negedge clk);
      while (!ahbls_hready_resp) begin
         cnt++;
         if (cnt > 200) bail("hready_stuck_low");
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic [31:0] r;
      for (int i = 0; i < n; i++) begin
         r = $urandom;
         case (r[1:0])
            2'd0:    drive(1'b0, HTRANS_NSEQ, r[4], $urandom, HSIZE_WORD);
            2'd1:    drive(1'b1, HTRANS_BUSY, r[4], $urandom, HSIZE_WORD);
            default: drive(1'b1, HTRANS_IDLE, r[4], $urandom, HSIZE_WORD);
         endcase
      end
   endtask

   // Issue one transfer; the model predicts the APB access and the AHB response from the rules.
   task automatic xfer(input logic write, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input int waits, input logic err,
                       input logic [31:0] rdata);
      ahb_exp_t    e;
      apb_exp_t    a;
      apb_rsp_t    r;
      logic [31:0] rr;
      if (write && size != HSIZE_WORD) begin
         e.err    = 1'b1;
         e.hrdata = mdl_hrdata;
         e.lat    = 2;
      end else begin
         a.write = write;
         a.addr  = addr[15:0];
         a.wdata = wdata;
         r.waits = waits;
         r.err   = err;
         r.rdata = rdata;
         apb_exp_q.push_back(a);
         apb_rsp_q.push_back(r);
         if (!write && !err) mdl_hrdata = rdata;
         e.err    = err;
         e.hrdata = mdl_hrdata;
         e.lat    = (write ? 4 : 3) + waits + (err ? 1 : 0);
      end
      ahb_exp_q.push_back(e);
      rr = $urandom;
      drive(1'b1, {1'b1, rr[0]}, write, addr, size);
      pend_wdata   = wdata;
      ahbls_hwdata = wdata;
   endtask

   // AHB response monitor
   logic     ahb_pending = 1'b0;
   int       ahb_lat = 0;
   logic     prev_rdy = 1'b1, prev_hresp = 1'b0;
   ahb_exp_t ahb_cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         ahb_pending = 1'b0;
      end else begin
         if (ahb_pending) begin
            ahb_lat++;
            if (ahbls_hready_resp) begin
               if (ahb_exp_q.size() == 0) bail("ahb_unexpected_response");
               ahb_cur = ahb_exp_q.pop_front();
               check("ahb_latency", ahb_lat, ahb_cur.lat);
               check("ahb_hresp", {31'd0, ahbls_hresp}, {31'd0, ahb_cur.err});
               check("ahb_hrdata", ahbls_hrdata, ahb_cur.hrdata);
               if (ahb_cur.err)
                  check("ahb_err_first_cycle", {30'd0, prev_rdy, prev_hresp}, 32'd1);
               ahb_pending = 1'b0;
            end
         end
         if (ahbls_hready_resp && ahbls_hsel && ahbls_htrans[1]) begin
            ahb_pending = 1'b1;
            ahb_lat     = 0;
         end
      end
      prev_rdy   = ahbls_hready_resp;
      prev_hresp = ahbls_hresp;
   end

   // APB subordinate model and access checker
   apb_exp_t apb_cur;
   apb_rsp_t apb_rsp;
   int       apb_wcnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         apbm_pready  = 1'b0;
         apbm_pslverr = 1'b0;
      end else if (apbm_psel && !apbm_penable) begin
         if (apb_exp_q.size() == 0 || apb_rsp_q.size() == 0) bail("apb_unexpected_psel");
         apb_cur  = apb_exp_q.pop_front();
         apb_rsp  = apb_rsp_q.pop_front();
         apb_wcnt = apb_rsp.waits;
         check("apb_setup_paddr", {16'd0, apbm_paddr}, {16'd0, apb_cur.addr});
         check("apb_setup_pwrite", {31'd0, apbm_pwrite}, {31'd0, apb_cur.write});
         if (apb_cur.write) check("apb_setup_pwdata", apbm_pwdata, apb_cur.wdata);
         apbm_pready  = 1'b0;
         apbm_pslverr = 1'b0;
      end else if (apbm_psel && apbm_penable) begin
         check("apb_access_paddr", {16'd0, apbm_paddr}, {16'd0, apb_cur.addr});
         check("apb_access_pwrite", {31'd0, apbm_pwrite}, {31'd0, apb_cur.write});
         if (apb_cur.write) check("apb_access_pwdata", apbm_pwdata, apb_cur.wdata);
         if (apb_wcnt == 0) begin
            apbm_pready  = 1'b1;
            apbm_pslverr = apb_rsp.err;
            apbm_prdata  = apb_rsp.rdata;
         end else begin
            apb_wcnt--;
            apbm_pready  = 1'b0;
            apbm_pslverr = 1'($urandom);
            apbm_prdata  = $urandom;
         end
      end else begin
         apbm_pready  = 1'b0;
         apbm_pslverr = 1'b0;
         apbm_prdata  = $urandom;
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_hready_resp"}, {31'd0, ahbls_hready_resp}, 32'd1);
      check({tag, "_hresp"}, {31'd0, ahbls_hresp}, 32'd0);
      check({tag, "_hrdata"}, ahbls_hrdata, 32'd0);
      check({tag, "_psel"}, {31'd0, apbm_psel}, 32'd0);
      check({tag, "_penable"}, {31'd0, apbm_penable}, 32'd0);
      check({tag, "_pwrite"}, {31'd0, apbm_pwrite}, 32'd0);
      check({tag, "_paddr"}, {16'd0, apbm_paddr}, 32'd0);
      check({tag, "_pwdata"}, apbm_pwdata, 32'd0);
   endtask

   initial begin
      logic [31:0] r, a;
      logic        wr;
      logic [2:0]  sz;
      int          cnt;
      ahbls_hsel   = 1'b0;
      ahbls_htrans = HTRANS_IDLE;
      ahbls_hwrite = 1'b0;
      ahbls_haddr  = '0;
      ahbls_hsize  = HSIZE_WORD;
      ahbls_hwdata = '0;
      apbm_prdata  = '0;
      apbm_pready  = 1'b0;
      apbm_pslverr = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases
      xfer(1'b0, 32'h0000_0104, HSIZE_WORD, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
      idle(2);
      xfer(1'b1, 32'h0000_0040, HSIZE_WORD, 32'h1234_5678, 3, 1'b0, 32'h0);
      idle(2);
      xfer(1'b0, 32'h0000_0080, HSIZE_WORD, 32'h0, 0, 1'b1, 32'h55AA_55AA);
      idle(1);
      xfer(1'b1, 32'h0000_0010, 3'd0, 32'hFFFF_FFFF, 0, 1'b0, 32'h0);
      idle(1);
      xfer(1'b0, 32'h0000_0004, HSIZE_WORD, 32'h0, 0, 1'b0, 32'hA5A5_0004);
      xfer(1'b1, 32'h0000_0008, HSIZE_WORD, 32'hC0DE_0008, 0, 1'b0, 32'h0);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         r  = $urandom;
         a  = $urandom;
         wr = r[0];
         if (wr) sz = (r[3:1] == 3'd0) ? {1'b0, r[5:4] == 2'd0 ? 2'd0 : 2'd1} : HSIZE_WORD;
         else    sz = {1'b0, r[5:4] == 2'd3 ? 2'd2 : r[5:4]};
         xfer(wr, a, sz, $urandom, int'(r[9:8]), r[12:10] == 3'd0, $urandom);
         if (r[15:14] == 2'd0) idle(int'(r[16]) + 1);
      end
      idle(2);

      // Asynchronous reset in the middle of an APB access
      xfer(1'b1, 32'h0000_ABC4, HSIZE_WORD, 32'h8765_4321, 6, 1'b0, 32'h0);
      cnt = 0;
      @(negedge clk);
      while (!(apbm_psel && apbm_penable)) begin
         cnt++;
         if (cnt > 10) bail("no_access_before_reset");
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_reset");
      apb_exp_q.delete();
      apb_rsp_q.delete();
      ahb_exp_q.delete();
      mdl_hrdata   = '0;
      pend_wdata   = '0;
      ahbls_hsel   = 1'b0;
      ahbls_htrans = HTRANS_IDLE;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      xfer(1'b0, 32'h0000_0300, HSIZE_WORD, 32'h0, 1, 1'b0, 32'h0BAD_F00D);
      idle(3);

      cnt = 0;
      while (ahb_exp_q.size() != 0 && cnt < 50) begin
         idle(1);
         cnt++;
      end
      check("ahb_queue_drained", ahb_exp_q.size(), 32'd0);
      check("apb_queue_drained", apb_exp_q.size(), 32'd0);
      check("apb_rsp_drained", apb_rsp_q.size(), 32'd0);
      finish_run();
   end

endmodule
